// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor index width, direction encoding and call-register defaults.
`default_nettype none
package elevator_pkg;
  localparam int FLOOR_W = 3;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DEFAULT_BUTTONS_WIDTH = 8;
  localparam int DEFAULT_DEBOUNCE = 4;
endpackage
`default_nettype wire

// File: rtl/btn_filter.sv
// One raw button: 2-flop synchronizer, saturating debounce counter, single accept pulse per press.
`default_nettype none
module btn_filter
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic accept
);
  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE);
  localparam logic [3:0] CNT_PRE = 4'(DEBOUNCE - 1);

  logic       sync_a;
  logic       sync_b;
  logic [3:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (!sync_b)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 4'd1;
    end
  end

  // Fires only on the DEBOUNCE-1 -> DEBOUNCE step; saturation blocks re-accept until seen low.
  assign accept = sync_b && (cnt == CNT_PRE);
endmodule
`default_nettype wire

// File: rtl/call_register.sv
// Latches car and hall calls from debounced buttons, clears them on serve, and summarizes
// pending calls relative to the car position.
`default_nettype none
module call_register
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH,
  parameter int DEBOUNCE      = DEFAULT_DEBOUNCE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
  input  logic                     serve_valid,
  input  logic [FLOOR_W-1:0]       serve_floor,
  input  logic                     serve_dir,
  input  logic [FLOOR_W-1:0]       current_floor,
  output logic [BUTTONS_WIDTH-1:0] req_in,
  output logic [BUTTONS_WIDTH-2:0] req_up,
  output logic [BUTTONS_WIDTH-1:1] req_down,
  output logic                     req_any,
  output logic                     req_above,
  output logic                     req_below,
  output logic                     req_here
);
  logic [BUTTONS_WIDTH-1:0] acc_in, clr_in, req_at;
  logic [BUTTONS_WIDTH-2:0] acc_up, clr_up;
  logic [BUTTONS_WIDTH-1:1] acc_down, clr_down;

  for (genvar i = 0; i < BUTTONS_WIDTH; i++) begin : g_car
    btn_filter #(.DEBOUNCE(DEBOUNCE)) u_flt (
      .clock(clock), .reset(reset), .raw(btn_in[i]), .accept(acc_in[i]));
  end

  for (genvar i = 0; i < BUTTONS_WIDTH - 1; i++) begin : g_hall_up
    btn_filter #(.DEBOUNCE(DEBOUNCE)) u_flt (
      .clock(clock), .reset(reset), .raw(btn_up_out[i]), .accept(acc_up[i]));
  end

  for (genvar i = 1; i < BUTTONS_WIDTH; i++) begin : g_hall_down
    btn_filter #(.DEBOUNCE(DEBOUNCE)) u_flt (
      .clock(clock), .reset(reset), .raw(btn_down_out[i]), .accept(acc_down[i]));
  end

  // End floors have only one hall button, so a serve there clears it whatever the direction.
  always_comb begin
    clr_in   = '0;
    clr_up   = '0;
    clr_down = '0;
    for (int f = 0; f < BUTTONS_WIDTH; f++)
      if (serve_valid && int'(serve_floor) == f)
        clr_in[f] = 1'b1;
    for (int f = 0; f < BUTTONS_WIDTH - 1; f++)
      if (serve_valid && int'(serve_floor) == f && (serve_dir == DIR_UP || f == 0))
        clr_up[f] = 1'b1;
    for (int f = 1; f < BUTTONS_WIDTH; f++)
      if (serve_valid && int'(serve_floor) == f &&
          (serve_dir == DIR_DOWN || f == BUTTONS_WIDTH - 1))
        clr_down[f] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_in   <= '0;
      req_up   <= '0;
      req_down <= '0;
    end else begin
      req_in   <= (req_in | acc_in) & ~clr_in;
      req_up   <= (req_up | acc_up) & ~clr_up;
      req_down <= (req_down | acc_down) & ~clr_down;
    end
  end

  assign req_at  = req_in | {1'b0, req_up} | {req_down, 1'b0};
  assign req_any = |req_at;

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    req_here  = 1'b0;
    if (int'(current_floor) < BUTTONS_WIDTH) begin
      for (int f = 0; f < BUTTONS_WIDTH; f++) begin
        if (req_at[f]) begin
          if (f > int'(current_floor))      req_above = 1'b1;
          else if (f < int'(current_floor)) req_below = 1'b1;
          else                              req_here  = 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_call_register.sv
// Directed checks of call_register: debounce latency, glitch rejection, serve clears, reset.
`default_nettype none
module tb_call_register;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] btn_in;
  logic [6:0] btn_up_out;
  logic [7:1] btn_down_out;
  logic       serve_valid;
  logic [2:0] serve_floor;
  logic       serve_dir;
  logic [2:0] current_floor;
  logic [7:0] req_in;
  logic [6:0] req_up;
  logic [7:1] req_down;
  logic       req_any, req_above, req_below, req_here;

  int vectors = 0;
  int miscompares = 0;

  call_register dut (
    .clock(clock), .reset(reset), .btn_in(btn_in), .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out), .serve_valid(serve_valid), .serve_floor(serve_floor),
    .serve_dir(serve_dir), .current_floor(current_floor), .req_in(req_in),
    .req_up(req_up), .req_down(req_down), .req_any(req_any), .req_above(req_above),
    .req_below(req_below), .req_here(req_here));

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [2:0] fl, input logic dir);
    serve_valid = 1'b1;
    serve_floor = fl;
    serve_dir   = dir;
    tick(1);
    serve_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in"}, 32'(req_in), 0);
    chk({tag, "_up"}, 32'(req_up), 0);
    chk({tag, "_down"}, 32'(req_down), 0);
    chk({tag, "_sum"}, {28'd0, req_any, req_above, req_below, req_here}, 0);
  endtask

  initial begin
    reset = 1'b0; btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    serve_valid = 1'b0; serve_floor = '0; serve_dir = 1'b0; current_floor = '0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(2);

    // Car call at floor 6: 5 clocks high, accepted on the 6th edge.
    btn_in[6] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (k == 5) btn_in[6] = 1'b0;
      chk($sformatf("car6_edge%0d", k), 32'(req_in), (k >= 6) ? 32'h40 : 32'h0);
    end
    tick(4);
    chk("car6_hold", 32'(req_in), 32'h40);
    chk("car6_sum", {28'd0, req_any, req_above, req_below, req_here}, 32'b1100);

    // Two-clock glitch on hall-up 2 latches nothing.
    btn_up_out[2] = 1'b1;
    tick(2);
    btn_up_out[2] = 1'b0;
    tick(8);
    chk("glitch_up", 32'(req_up), 0);
    chk("glitch_down", 32'(req_down), 0);

    // Hall up and down at floor 3, serve going up clears only the up call.
    btn_up_out[3] = 1'b1; btn_down_out[3] = 1'b1;
    tick(5);
    btn_up_out[3] = 1'b0; btn_down_out[3] = 1'b0;
    tick(2);
    current_floor = 3'd3;
    chk("f3_up_set", 32'(req_up), 32'h08);
    chk("f3_down_set", 32'(req_down), 32'h04);
    serve(3'd3, 1'b1);
    chk("f3_up_clr", 32'(req_up), 0);
    chk("f3_down_kept", 32'(req_down), 32'h04);
    chk("f3_sum", {28'd0, req_any, req_above, req_below, req_here}, 32'b1101);
    serve(3'd3, 1'b0);
    serve(3'd6, 1'b1);
    chk("f3_f6_cleared", {24'd0, req_in} | {25'd0, req_down}, 0);

    // End floors: serves clear the single hall call regardless of direction.
    btn_up_out[0] = 1'b1; btn_down_out[7] = 1'b1;
    tick(5);
    btn_up_out[0] = 1'b0; btn_down_out[7] = 1'b0;
    tick(2);
    chk("ends_set", {25'd0, req_up, req_down}, {25'd0, 7'h01, 7'h40});
    chk("ends_below_above", {30'd0, req_above, req_below}, 32'b11);
    serve(3'd0, 1'b0);
    serve(3'd7, 1'b1);
    chk("ends_clr", {25'd0, req_up, req_down}, 0);

    // Held car button 4: serve clears it, no re-latch until release and a fresh press.
    btn_in[4] = 1'b1;
    tick(6);
    chk("hold4_set", 32'(req_in), 32'h10);
    serve(3'd4, 1'b0);
    chk("hold4_clr", 32'(req_in), 0);
    tick(10);
    chk("hold4_stays", 32'(req_in), 0);
    btn_in[4] = 1'b0;
    tick(3);
    btn_in[4] = 1'b1;
    tick(6);
    chk("hold4_repress", 32'(req_in), 32'h10);
    btn_in[4] = 1'b0;
    serve(3'd4, 1'b1);

    // Clear wins when the accept edge of car 2 coincides with a serve at floor 2.
    btn_in[2] = 1'b1;
    tick(5);
    serve_valid = 1'b1; serve_floor = 3'd2; serve_dir = 1'b1;
    tick(1);
    serve_valid = 1'b0;
    chk("collide2", 32'(req_in), 0);
    btn_in[2] = 1'b0;
    tick(6);
    chk("collide2_after", 32'(req_in), 0);

    // All buttons pressed, reset mid-debounce discards everything.
    btn_in = 8'hFF; btn_up_out = 7'h7F; btn_down_out = 7'h7F;
    tick(3);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    tick(2);
    reset = 1'b1;
    tick(10);
    chk_all_zero("post_reset");

    // Button held through reset release is accepted once after full sync and debounce.
    btn_in[1] = 1'b1;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(5);
    chk("held_rst_early", 32'(req_in), 0);
    tick(1);
    chk("held_rst_accept", 32'(req_in), 32'h02);
    btn_in[1] = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/call_register.md
CALL_REGISTER -- requirements
Module: call_register

Interface
REQ-001 Parameter BUTTONS_WIDTH, default 8: number of floors; floor index width is 3 at the default.
REQ-002 Parameter DEBOUNCE, default 4: consecutive synchronized-high cycles needed to accept a press; legal range 2..15.
REQ-003 clock  input  1  single system clock; all flops rise-edge triggered.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_in  input  BUTTONS_WIDTH  raw car buttons, one per floor, asynchronous.
REQ-006 btn_up_out  input  [BUTTONS_WIDTH-2:0]  raw hall-up buttons, floors 0..6, asynchronous.
REQ-007 btn_down_out  input  [BUTTONS_WIDTH-1:1]  raw hall-down buttons, floors 1..7, asynchronous.
REQ-008 serve_valid  input  1  controller stopped with doors opening at serve_floor; single-cycle strobe.
REQ-009 serve_floor  input  3  floor being served.
REQ-010 serve_dir  input  1  committed travel direction at the stop; 1 = up, 0 = down.
REQ-011 current_floor  input  3  floor the car is at or last passed.
REQ-012 req_in  output  BUTTONS_WIDTH  latched car calls.
REQ-013 req_up  output  [BUTTONS_WIDTH-2:0]  latched hall-up calls.
REQ-014 req_down  output  [BUTTONS_WIDTH-1:1]  latched hall-down calls.
REQ-015 req_any, req_above, req_below, req_here  output  1 each  pending-call summaries relative to current_floor.

Function
REQ-016 Each raw button SHALL pass through a 2-flop synchronizer and then a saturating counter: +1 when synchronized level is 1, cleared to 0 when it is 0, saturating at DEBOUNCE.
REQ-017 A press SHALL be accepted only on the edge where the counter goes from DEBOUNCE-1 to DEBOUNCE, producing one accept per press; a held button SHALL not re-accept until it has been seen low.
REQ-018 On accept, the matching request bit SHALL be set on that same edge. Latency is DEBOUNCE+2 edges from the first edge sampling the raw input high; the raw input must stay high for DEBOUNCE sampling edges.
REQ-019 Glitches shorter than DEBOUNCE cycles SHALL set nothing.
REQ-020 A press for an already-set bit SHALL have no effect, with no toggle and no clear.
REQ-021 On serve_valid, req_in[serve_floor] SHALL clear.
REQ-022 On serve_valid with serve_dir=1, req_up[serve_floor] SHALL clear; with serve_dir=0, req_down[serve_floor] SHALL clear.
REQ-023 At floor 0, a serve SHALL clear req_up[0] regardless of serve_dir; at floor BUTTONS_WIDTH-1, a serve SHALL clear req_down[top] regardless of serve_dir.
REQ-024 When a clear and an accept hit the same bit on the same edge, the clear SHALL win.
REQ-025 Non-existent bits (up at the top floor, down at floor 0) SHALL be ignored.
REQ-026 req_any SHALL be the OR of all request bits; it is combinational from the registers.
REQ-027 req_above and req_below SHALL be any request of any type at a floor strictly greater / strictly less than current_floor; req_here SHALL be any request at current_floor.
REQ-028 serve_floor or current_floor >= BUTTONS_WIDTH SHALL clear nothing and contribute to no summary.

Reset
REQ-029 While reset=0, all request bits, synchronizer flops and counters SHALL be 0, and all outputs SHALL be 0.
REQ-030 A button held through reset release SHALL go through the full sync and debounce again and then be accepted once.
REQ-031 A reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-032 Shared package elevator_pkg SHALL hold FLOOR_W=3, DIR_UP=1, DIR_DOWN=0 and the default BUTTONS_WIDTH and DEBOUNCE.
REQ-033 Sub-module btn_filter (synchronizer, counter, accept pulse) SHALL be instantiated once per physical button (22 instances at the default).
REQ-034 call_register SHALL contain only the request registers, the clear decode and the summaries.

Verification
REQ-035 btn_in[6] high for 5 clocks, then low -> req_in[6]=1 exactly 6 edges after the first high sample and stays 1; req_above=1 with current_floor=0.
REQ-036 btn_up_out[2] high for 2 clocks -> no request bit ever set.
REQ-037 req_up[3] and req_down[3] set, then serve_valid, serve_floor=3, serve_dir=1 -> req_up[3]=0 next edge; req_down[3] stays 1; req_here=1 with current_floor=3.
REQ-038 btn_in[4] held continuously; serve floor 4 clears req_in[4] -> req_in[4] stays 0 until release and a fresh press.
REQ-039 Accept edge of btn_in[2] coincides with serve_valid at floor 2 -> req_in[2]=0.
REQ-040 All 22 buttons pressed together, then reset pulsed low mid-debounce -> all outputs 0; after release with buttons low, nothing latches.
